// File: rtl/out_eval_ctrl_if.sv
// ============================================================================
// out_eval_ctrl_if : LBIST out_eval control/status and MISR bundle
// Optional port sig_cap is present only with OUT_EVAL_SIG_CAPTURE_EN defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface out_eval_ctrl_if #(
  parameter int N     = 24,
  parameter int CNT_W = 16
);
  logic             start;
  logic [N-1:0]     misr_sig;
  logic             misr_en;
  logic             misr_rst_n;
  logic [CNT_W-1:0] pat_cnt;
  logic             busy;
  logic             done;
  logic             pass;
`ifdef OUT_EVAL_SIG_CAPTURE_EN
  logic [N-1:0]     sig_cap;

  modport slave (
    input  start, misr_sig,
    output misr_en, misr_rst_n, pat_cnt, busy, done, pass, sig_cap
  );
  modport master (
    output start, misr_sig,
    input  misr_en, misr_rst_n, pat_cnt, busy, done, pass, sig_cap
  );
`else
  modport slave (
    input  start, misr_sig,
    output misr_en, misr_rst_n, pat_cnt, busy, done, pass
  );
  modport master (
    output start, misr_sig,
    input  misr_en, misr_rst_n, pat_cnt, busy, done, pass
  );
`endif
endinterface

`default_nettype wire

// File: rtl/out_eval_ctrl.sv
// ============================================================================
// out_eval_ctrl : LBIST output-evaluation session controller (seed/run/check)
// Optional: OUT_EVAL_SIG_CAPTURE_EN adds the sig_cap diagnostic register.
// Revision: 1.0
// ============================================================================
`default_nettype none

module out_eval_ctrl #(
  parameter int             N        = 24,
  parameter int             PATTERNS = 1000,
  parameter int             CNT_W    = 16,
  parameter logic [N-1:0]   GOLDEN   = '0
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  out_eval_ctrl_if.slave   ctrl
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEED  = 3'd1,
    ST_RUN   = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(PATTERNS - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pass_q, pass_d;
  logic             en_q;
  logic             misr_rst_n_q;
  logic             busy_q;
  logic             done_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    case (state_q)
      ST_IDLE:  if (ctrl.start) state_d = ST_SEED;
      ST_SEED:  state_d = ST_RUN;
      ST_RUN: begin
        if (cnt_q == C_LAST) state_d = ST_CHECK;
        else                 cnt_d   = cnt_q + 1'b1;
      end
      ST_CHECK: begin
        pass_d  = (ctrl.misr_sig == GOLDEN);
        state_d = ST_DONE;
      end
      ST_DONE:  if (ctrl.start) state_d = ST_SEED;
      default:  state_d = ST_IDLE;
    endcase
    // Entering SEED wipes the previous result and rewinds the pattern index.
    if (state_d == ST_SEED) begin
      cnt_d  = '0;
      pass_d = 1'b0;
    end
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      pass_q       <= 1'b0;
      en_q         <= 1'b0;
      misr_rst_n_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pass_q       <= pass_d;
      en_q         <= (state_d == ST_RUN);
      misr_rst_n_q <= (state_d != ST_SEED);
      busy_q       <= (state_d inside {ST_SEED, ST_RUN, ST_CHECK});
      done_q       <= (state_d == ST_DONE);
    end
  end

`ifdef OUT_EVAL_SIG_CAPTURE_EN
  logic [N-1:0] sig_cap_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  sig_cap_q <= '0;
    else if (state_q == ST_CHECK) sig_cap_q <= ctrl.misr_sig;
  end

  assign ctrl.sig_cap = sig_cap_q;
`endif

  assign ctrl.misr_en    = en_q;
  assign ctrl.misr_rst_n = misr_rst_n_q;
  assign ctrl.pat_cnt    = cnt_q;
  assign ctrl.busy       = busy_q;
  assign ctrl.done       = done_q;
  assign ctrl.pass       = pass_q;

endmodule

`default_nettype wire

// File: doc/out_eval_ctrl.md
# out_eval_ctrl

Output-evaluation controller for the LBIST signature path. It sequences one test session: reseeds the downstream-of-CUT MISR, enables it for exactly `PATTERNS` clock cycles, freezes it, then compares the frozen signature against a compile-time golden value. It reports `busy`, `done` and `pass` to the LBIST top-level. It sits beside the MISR in the out_eval stage, drives the MISR's `en` and `rst_n`, and consumes the MISR's `dout`.

## Interface
- `N`, 24, signature width; must equal the MISR `N`.
- `PATTERNS`, 1000, number of MISR capture cycles per session; legal range 1 .. 2^CNT_W-1.
- `CNT_W`, 16, width of the pattern counter.
- `GOLDEN`, 24'h000000, expected fault-free signature (N bits).
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  session request; level-sampled in IDLE and DONE only.
- `misr_sig`  in  N  MISR `dout`.
- `misr_en`  out  1  MISR capture enable.
- `misr_rst_n`  out  1  MISR reseed (active-low, registered, glitch-free).
- `pat_cnt`  out  CNT_W  index of the pattern being captured, for TPG alignment.
- `busy`  out  1  session in progress.
- `done`  out  1  result valid.
- `pass`  out  1  signature matched `GOLDEN`; meaningful only while `done`=1.

## Operation
- Moore FSM with states IDLE, SEED, RUN, CHECK, DONE. All outputs are registered and decoded from the state and counter registers.
- IDLE: `start`=1 → SEED; otherwise stay.
- SEED (1 cycle): `misr_rst_n`=0, `busy`=1. Always → RUN; `pat_cnt` cleared to 0.
- RUN: `misr_en`=1, `busy`=1.
  - If `pat_cnt` == PATTERNS-1: → CHECK.
  - Else `pat_cnt` increments.
  - The MISR therefore captures exactly PATTERNS inputs.
- CHECK (1 cycle): `misr_en`=0, `busy`=1, `misr_sig` is stable. The `pass` register loads (`misr_sig` == GOLDEN), full N-bit equality. → DONE.
- DONE: `done`=1, `busy`=0, `pass` held, `pat_cnt` held at PATTERNS-1.
  - `start`=1 → SEED, a new session. `done` and `pass` clear on entry to SEED.
  - Otherwise stay.
- `start` in SEED, RUN or CHECK is ignored; there is no restart and no queuing.
- `misr_rst_n` is 1 in every state except SEED.
- PATTERNS=1: RUN lasts exactly one cycle.
- Reset values (asynchronous, reset mid-session included): state IDLE, `misr_en`=0, `misr_rst_n`=0, `pat_cnt`=0, `busy`=0, `done`=0, `pass`=0.
  - `misr_rst_n` is released to 1 on the first clock edge after `rst_n` deasserts.
  - A session interrupted by reset leaves no result; `done` stays 0 until a full new session completes.

## Timing
- Edge E0 samples `start`=1 in IDLE or DONE. SEED occupies the cycle after E0.
- RUN covers P=PATTERNS cycles, from the cycle after E1 through E(P+1).
- CHECK occupies the cycle after E(P+1). `done` and `pass` are visible after E(P+2), i.e. P+2 cycles after E0.
- `misr_en` is high for exactly P consecutive cycles per session. No bubbles.
- `pat_cnt` equals k during the k-th RUN cycle, k = 0 .. P-1.
- Back-to-back sessions: `start` held high in DONE re-enters SEED on the next edge. The minimum session period is P+3 cycles.

## Configuration
- `OUT_EVAL_SIG_CAPTURE_EN`
  - Defined: adds output port `sig_cap` (out, N). It resets to 0, loads `misr_sig` in CHECK alongside `pass`, and holds until the next CHECK; this is for diagnosis of failing sessions.
  - Undefined: port and register are absent; all other behaviour is identical.

## Test plan
Bench configuration: N=24, PATTERNS=4, GOLDEN=24'hABCDEF. `misr_sig` is driven by a behavioural MISR model seeded with 100.
- Reset, then idle 5 cycles → `misr_rst_n`=1 from the first edge after release; `misr_en`, `busy`, `done`, `pass` and `pat_cnt` all 0.
- Pulse `start` 1 cycle, with the model forced so the final signature = 24'hABCDEF:
  - `misr_rst_n`=0 for exactly 1 cycle.
  - `misr_en`=1 for 4 cycles, with `pat_cnt` 0,1,2,3.
  - `done`=1 and `pass`=1 exactly 6 cycles after the start edge. `sig_cap`=24'hABCDEF when the macro is defined.
- Same session with final signature 24'hABCDEE → `done`=1, `pass`=0 (single-bit mismatch detected).
- Hold `start`=1 continuously → sessions repeat every 7 cycles. `start` during RUN never shortens `misr_en` below 4 cycles.
- Assert `rst_n`=0 during the 2nd RUN cycle → all outputs return to reset values immediately. `done` stays 0 until a new `start`.
- Rebuild with PATTERNS=1 → `misr_en` high 1 cycle; `done` 3 cycles after the start edge.
